// File: rtl/sram_ctrl_pkg.sv
// Shared types and static macro tie-offs for the SRAM port controllers.
package sram_ctrl_pkg;

    // Port controller sequencing: zero-fill sweep, then normal traffic.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

    // Static macro trim / test pins.
    localparam logic [3:0] SRAM_RM_DEFAULT    = 4'b0010;
    localparam logic       SRAM_RME_DEFAULT   = 1'b0;
    localparam logic       SRAM_TEST1_DEFAULT = 1'b0;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read data returned by the macro.
// Supports push and pop in the same cycle; reports its occupancy.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic [DATA_W-1:0]                    push_data,
    input  logic                                 pop,
    output logic [DATA_W-1:0]                    pop_data,
    output logic                                 empty,
    output logic [cnt_width(RSP_DEPTH)-1:0]      occ
);

    localparam int unsigned OCC_W = cnt_width(RSP_DEPTH);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              full;
    logic              push_ok, pop_ok;

    // Pointer advance with wrap at a depth that need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (occ_q == OCC_W'(RSP_DEPTH));
    assign empty = (occ_q == '0);
    // A push into a full buffer is only legal when an entry leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Data storage; contents are only observed through valid entries, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign occ      = occ_q;

endmodule

// File: rtl/sram_dp_port_ctrl.sv
// Initiator for one port of the dual-port node-store SRAM macro.
// Turns a valid/ready request stream into macro strobes, absorbs the registered-Q
// latency and returns read data in request order on a valid/ready response stream.
// Optionally zero-fills the whole array after reset before accepting traffic.
module sram_dp_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned RSP_DEPTH      = 3,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    // request stream
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    // macro port
    output logic              sram_me,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_adr,
    output logic [DATA_W-1:0] sram_d,
    output logic [DATA_W-1:0] sram_wem,
    input  logic [DATA_W-1:0] sram_q,
    output logic              sram_test1,
    output logic              sram_rme,
    output logic [3:0]        sram_rm
);

    localparam int unsigned OCC_W = cnt_width(RSP_DEPTH);
    // Occupancy plus one in-flight read can reach RSP_DEPTH + 1.
    localparam int unsigned CNT_W = cnt_width(RSP_DEPTH + 1);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic              init_done_q;
    logic              req_ready_q, req_ready_d;
    logic              inflight_q, inflight_d;

    logic              req_fire;
    logic              rd_fire;
    logic              clearing;
    logic              clear_last;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic [OCC_W-1:0]  fifo_occ;

    logic [CNT_W-1:0]  occ_nxt;
    logic [CNT_W-1:0]  outstanding_nxt;

    // Request handshake; req_ready_q is only ever set while in RUN.
    assign req_fire = req_valid & req_ready_q;
    assign rd_fire  = req_fire & ~req_we;

    // Sweep writes are held off while reset is asserted so the macro sees no strobes.
    assign clearing   = (state_q == ST_CLEAR) & rst_n;
    assign clear_last = (clear_addr_q == {ADDR_W{1'b1}});

    // Macro strobes: sweep writes during CLEAR, pass-through of accepted requests in RUN.
    always_comb begin
        sram_me  = 1'b0;
        sram_we  = 1'b0;
        sram_adr = '0;
        sram_d   = '0;
        sram_wem = '0;
        if (clearing) begin
            sram_me  = 1'b1;
            sram_we  = 1'b1;
            sram_adr = clear_addr_q;
            sram_d   = '0;
            sram_wem = {DATA_W{1'b1}};
        end else if (req_fire) begin
            sram_me  = 1'b1;
            sram_we  = req_we;
            sram_adr = req_addr;
            sram_d   = req_wdata;
            sram_wem = req_we ? req_wmask : '0;
        end
    end

    // The macro presents Q one cycle after a read strobe; capture it then.
    assign fifo_push = inflight_q;
    assign fifo_pop  = rsp_valid & rsp_ready;

    sram_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (sram_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .occ       (fifo_occ)
    );

    // Next-state: sweep progress, in-flight tracking and registered request credit.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        if (state_q == ST_CLEAR) begin
            if (clear_last) begin
                state_d = ST_RUN;
            end else begin
                clear_addr_d = clear_addr_q + ADDR_W'(1);
            end
        end
        inflight_d = rd_fire;
        // Look ahead one cycle so req_ready can be a flop with no path from rsp_ready.
        occ_nxt         = CNT_W'(fifo_occ) + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        outstanding_nxt = occ_nxt + CNT_W'(inflight_d);
        req_ready_d     = (state_d == ST_RUN) && (outstanding_nxt < CNT_W'(RSP_DEPTH));
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clear_addr_q <= '0;
            init_done_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            init_done_q  <= init_done_q | (state_q == ST_RUN);
            req_ready_q  <= req_ready_d;
            inflight_q   <= inflight_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign init_done  = init_done_q;
    assign rsp_valid  = ~fifo_empty;
    // Keep the data bus quiet when nothing is presented.
    assign rsp_rdata  = rsp_valid ? fifo_data : '0;

    assign sram_test1 = SRAM_TEST1_DEFAULT;
    assign sram_rme   = SRAM_RME_DEFAULT;
    assign sram_rm    = SRAM_RM_DEFAULT;

endmodule
